// File: rtl/div_pkg.sv
// Shared types for the divide-unit arbiter: FSM states, default widths and the per-lane request record.
package div_pkg;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_TAG_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } div_state_e;

    typedef struct packed {
        logic [DIV_XLEN-1:0]  a;
        logic [DIV_XLEN-1:0]  b;
        logic                 sgn;
        logic                 rem;
        logic [DIV_TAG_W-1:0] tag;
    } div_req_t;

endpackage

// File: rtl/div_arbiter_rr_arb2.sv
// Two-input round-robin picker: rr=0 prefers lane 0, rr=1 prefers lane 1; grant is one-hot or zero.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid[0] && (!rr || !valid[1])) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one multi-cycle divider between two requesters, one operation in flight at a time.
// Optional build macro DIV_ZERO_BYPASS_EN: divisor-0 requests skip the divider and answer directly.
module div_arbiter
    import div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int TAG_W = DIV_TAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*XLEN-1:0]    req_a,
    input  logic [2*XLEN-1:0]    req_b,
    input  logic [1:0]           req_signed,
    input  logic [1:0]           req_rem,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic [1:0]           resp_valid,
    input  logic [1:0]           resp_ready,
    output logic [XLEN-1:0]      resp_data,
    output logic [TAG_W-1:0]     resp_tag,
    output logic                 div_start,
    output logic [XLEN-1:0]      div_a,
    output logic [XLEN-1:0]      div_b,
    output logic                 div_signed,
    input  logic                 div_done,
    input  logic [XLEN-1:0]      div_quot,
    input  logic [XLEN-1:0]      div_rem,
    output logic                 busy
);

    div_state_e           state_reg, state_next;
    logic                 rr_reg, rr_next;
    logic                 owner_reg, owner_next;
    div_req_t             req_reg, req_next;
    logic [XLEN-1:0]      result_reg, result_next;

    div_req_t [1:0]       lane_req;
    logic [1:0]           grant;
    logic                 win;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign lane_req[gi].a   = req_a[gi*XLEN +: XLEN];
        assign lane_req[gi].b   = req_b[gi*XLEN +: XLEN];
        assign lane_req[gi].sgn = req_signed[gi];
        assign lane_req[gi].rem = req_rem[gi];
        assign lane_req[gi].tag = req_tag[gi*TAG_W +: TAG_W];

        assign req_ready[gi]  = (state_reg == IDLE) && grant[gi];
        assign resp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
    end

    rr_arb2 u_rr_arb2 (
        .valid (req_valid),
        .rr    (rr_reg),
        .grant (grant)
    );

    assign win        = grant[1];
    assign div_start  = (state_reg == ISSUE);
    assign div_a      = req_reg.a;
    assign div_b      = req_reg.b;
    assign div_signed = req_reg.sgn;
    assign resp_data  = result_reg;
    assign resp_tag   = req_reg.tag;
    assign busy       = (state_reg != IDLE);

    always_comb begin
        state_next  = state_reg;
        rr_next     = rr_reg;
        owner_next  = owner_reg;
        req_next    = req_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (grant != 2'b00) begin
                    owner_next = win;
                    req_next   = lane_req[win];
`ifdef DIV_ZERO_BYPASS_EN
                    if (lane_req[win].b == '0) begin
                        result_next = lane_req[win].rem ? lane_req[win].a : '1;
                        state_next  = RESP;
                    end else begin
                        state_next  = ISSUE;
                    end
`else
                    state_next = ISSUE;
`endif
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                // div_done is only meaningful here; stray pulses elsewhere are dropped
                if (div_done) begin
                    result_next = req_reg.rem ? div_rem : div_quot;
                    state_next  = RESP;
                end
            end
            RESP: begin
                if (resp_ready[owner_reg]) begin
                    rr_next    = ~owner_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            rr_reg     <= 1'b0;
            owner_reg  <= 1'b0;
            req_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            rr_reg     <= rr_next;
            owner_reg  <= owner_next;
            req_reg    <= req_next;
            result_reg <= result_next;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural variable-latency divider.
module tb_div_arbiter;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [1:0]          req_valid = '0;
    logic [1:0]          req_ready;
    logic [2*XLEN-1:0]   req_a = '0;
    logic [2*XLEN-1:0]   req_b = '0;
    logic [1:0]          req_signed = '0;
    logic [1:0]          req_rem = '0;
    logic [2*TAG_W-1:0]  req_tag = '0;
    logic [1:0]          resp_valid;
    logic [1:0]          resp_ready = '0;
    logic [XLEN-1:0]     resp_data;
    logic [TAG_W-1:0]    resp_tag;
    logic                div_start;
    logic [XLEN-1:0]     div_a;
    logic [XLEN-1:0]     div_b;
    logic                div_signed;
    logic                div_done = 1'b0;
    logic [XLEN-1:0]     div_quot = '0;
    logic [XLEN-1:0]     div_rem = '0;
    logic                busy;

    int n_checks  = 0;
    int n_fail    = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    int dm_lat    = 1;
    int dm_cnt    = 0;
    logic [31:0] dm_q = '0;
    logic [31:0] dm_r = '0;

    always #5 clk = ~clk;

    div_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .req_rem    (req_rem),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_signed (div_signed),
        .div_done   (div_done),
        .div_quot   (div_quot),
        .div_rem    (div_rem),
        .busy       (busy)
    );

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (sgn) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Divider model: done pulse arrives dm_lat cycles after the start cycle; results are junk otherwise.
    always @(negedge clk) begin
        div_done = (dm_cnt == 1);
        div_quot = div_done ? dm_q : 32'hDEAD_BEEF;
        div_rem  = div_done ? dm_r : 32'hBAAD_F00D;
        if (div_done) done_cnt = done_cnt + 1;
        if (dm_cnt > 0) dm_cnt = dm_cnt - 1;
        if (div_start) begin
            start_cnt = start_cnt + 1;
            dm_cnt = dm_lat;
            ref_div(div_a, div_b, div_signed, dm_q, dm_r);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_lane(input int lane, input logic [31:0] a, input logic [31:0] b,
                            input logic sgn, input logic rem, input logic [4:0] tag);
        req_a[lane*XLEN +: XLEN]   = a;
        req_b[lane*XLEN +: XLEN]   = b;
        req_signed[lane]           = sgn;
        req_rem[lane]              = rem;
        req_tag[lane*TAG_W +: TAG_W] = tag;
    endtask

    task automatic wait_resp(input logic [1:0] exp_oh, input logic [31:0] exp_data,
                             input logic [4:0] exp_tag, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (resp_valid == 2'b00 && n < 100);
        chk({nm, " resp_valid"}, 32'(resp_valid), 32'(exp_oh));
        chk({nm, " resp_data"}, resp_data, exp_data);
        chk({nm, " resp_tag"}, 32'(resp_tag), 32'(exp_tag));
        $display("txn %s: lane_oh=%b data=0x%08h tag=%0d", nm, resp_valid, resp_data, resp_tag);
    endtask

    task automatic run_txn(input int lane, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic rem, input logic [4:0] tag,
                           input int dlat, input logic [31:0] exp, input string nm);
        int s0, cyc, exp_lat, exp_starts;
        logic [1:0] oh;
        oh = (lane == 0) ? 2'b01 : 2'b10;
        exp_lat = 2 + dlat;
        exp_starts = 1;
`ifdef DIV_ZERO_BYPASS_EN
        if (b == 32'd0) begin
            exp_lat = 1;
            exp_starts = 0;
        end
`endif
        dm_lat = dlat;
        resp_ready = 2'b11;
        @(negedge clk);
        set_lane(lane, a, b, sgn, rem, tag);
        req_valid = oh;
        #1;
        chk({nm, " req_ready"}, 32'(req_ready), 32'(oh));
        s0 = start_cnt;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) req_valid = 2'b00;
            #1;
            if (cyc == 1) begin
                chk({nm, " div_start"}, 32'(div_start), 32'(exp_starts));
                if (exp_starts == 1) begin
                    chk({nm, " div_a"}, div_a, a);
                    chk({nm, " div_b"}, div_b, b);
                end
            end
        end while (resp_valid == 2'b00 && cyc < 100);
        chk({nm, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({nm, " resp_valid"}, 32'(resp_valid), 32'(oh));
        chk({nm, " resp_data"}, resp_data, exp);
        chk({nm, " resp_tag"}, 32'(resp_tag), 32'(tag));
        chk({nm, " starts"}, 32'(start_cnt - s0), 32'(exp_starts));
        @(negedge clk); #1;
        chk({nm, " resp_drop"}, 32'(resp_valid), 32'd0);
        chk({nm, " idle"}, 32'(busy), 32'd0);
        $display("txn %s: lane=%0d data=0x%08h tag=%0d latency=%0d", nm, lane, resp_data, resp_tag, cyc);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " req_ready"}, 32'(req_ready), 32'd0);
        chk({nm, " resp_valid"}, 32'(resp_valid), 32'd0);
        chk({nm, " div_start"}, 32'(div_start), 32'd0);
        chk({nm, " resp_data"}, resp_data, 32'd0);
        chk({nm, " resp_tag"}, 32'(resp_tag), 32'd0);
        chk({nm, " div_a"}, div_a, 32'd0);
        chk({nm, " div_b"}, div_b, 32'd0);
        chk({nm, " div_signed"}, 32'(div_signed), 32'd0);
    endtask

    typedef struct {
        int          lane;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        rem;
        logic [4:0]  tag;
        int          dlat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, bad, d0;

        vecs[0] = '{0, 32'd100,         32'd7,          1'b0, 1'b0, 5'd3,  8, 32'd14};
        vecs[1] = '{1, 32'hFFFF_FFF9,   32'd2,          1'b1, 1'b1, 5'd7,  3, 32'hFFFF_FFFF};
        vecs[2] = '{0, 32'hFFFF_FFF9,   32'd2,          1'b1, 1'b0, 5'd9,  1, 32'hFFFF_FFFD};
        vecs[3] = '{1, 32'hFFFF_FFF9,   32'd2,          1'b0, 1'b0, 5'd31, 2, 32'h7FFF_FFFC};
        vecs[4] = '{0, 32'h8000_0000,   32'hFFFF_FFFF,  1'b1, 1'b0, 5'd0,  4, 32'h8000_0000};
        vecs[5] = '{0, 32'h0000_1234,   32'd0,          1'b0, 1'b0, 5'd10, 3, 32'hFFFF_FFFF};
        vecs[6] = '{1, 32'h0000_1234,   32'd0,          1'b0, 1'b1, 5'd11, 3, 32'h0000_1234};
        vecs[7] = '{1, 32'd1000,        32'd33,         1'b0, 1'b1, 5'd17, 5, 32'd10};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].lane, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].rem,
                    vecs[i].tag, vecs[i].dlat, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Simultaneous requests right after reset: lane0, lane1, then lane0 again
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        dm_lat = 2;
        resp_ready = 2'b11;
        @(negedge clk);
        set_lane(0, 32'd50, 32'd5, 1'b0, 1'b0, 5'd1);
        set_lane(1, 32'd9,  32'd3, 1'b0, 1'b0, 5'd2);
        req_valid = 2'b11;
        #1;
        chk("sim first grant", 32'(req_ready), 32'b01);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        chk("sim ready low in ISSUE", 32'(req_ready), 32'd0);
        wait_resp(2'b01, 32'd10, 5'd1, "sim lane0");
        @(negedge clk); #1;
        chk("sim second grant", 32'(req_ready), 32'b10);
        @(negedge clk);
        req_valid = 2'b00;
        wait_resp(2'b10, 32'd3, 5'd2, "sim lane1");
        @(negedge clk);
        set_lane(0, 32'd50, 32'd5, 1'b0, 1'b1, 5'd4);
        req_valid = 2'b11;
        #1;
        chk("sim third grant", 32'(req_ready), 32'b01);
        @(negedge clk);
        req_valid = 2'b00;
        wait_resp(2'b01, 32'd0, 5'd4, "sim lane0 again");

        // Back-pressure on lane1 while lane0 is waiting to be served
        @(negedge clk);
        dm_lat = 2;
        resp_ready = 2'b01;
        set_lane(1, 32'd100, 32'd7, 1'b0, 1'b0, 5'd5);
        req_valid = 2'b10;
        @(negedge clk);
        set_lane(0, 32'd20, 32'd4, 1'b0, 1'b0, 5'd6);
        req_valid = 2'b01;
        wait_resp(2'b10, 32'd14, 5'd5, "bp lane1");
        s0 = start_cnt;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (resp_valid !== 2'b10 || resp_data !== 32'd14 || resp_tag !== 5'd5 || req_ready !== 2'b00)
                bad++;
        end
        chk("bp hold stable", 32'(bad), 32'd0);
        chk("bp no restart", 32'(start_cnt - s0), 32'd0);
        resp_ready = 2'b10;
        @(negedge clk); #1;
        chk("bp resp dropped", 32'(resp_valid), 32'd0);
        chk("bp next grant", 32'(req_ready), 32'b01);
        @(negedge clk);
        req_valid = 2'b00;
        resp_ready = 2'b11;
        wait_resp(2'b01, 32'd5, 5'd6, "bp lane0");

        // Reset while waiting on the divider; the late done pulse must be ignored
        @(negedge clk);
        dm_lat = 8;
        set_lane(0, 32'd100, 32'd7, 1'b0, 1'b0, 5'd3);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst busy in WAIT", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst mid-op");
        @(negedge clk);
        rst = 1'b1;
        d0 = done_cnt;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (resp_valid !== 2'b00 || busy !== 1'b0) bad++;
        end
        chk("rst late done seen", 32'(done_cnt - d0), 32'd1);
        chk("rst no response", 32'(bad), 32'd0);
        run_txn(1, 32'd77, 32'd7, 1'b0, 1'b0, 5'd12, 2, 32'd11, "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
